// File: rtl/muldiv_seq.sv
// Sequencer and shared-adder arbiter for the iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Optional one-entry result cache enabled by defining MULDIV_SEQ_CACHE_EN.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic        mul_en_o,
    output logic [2:0]  mul_funct3_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic        mul_finish_i,
    input  logic [31:0] mul_result_i,
    input  logic [31:0] mul_opa_i,
    input  logic [31:0] mul_opb_i,
    input  logic [31:0] alu_opa_i,
    input  logic [31:0] alu_opb_i,
    output logic [31:0] adder_opa_o,
    output logic [31:0] adder_opb_o,
    output logic        alu_stall_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [4:0]  rd_reg, rd_next;
    logic [31:0] data_reg, data_next;
    logic        err_reg, err_next;

    logic        accept;
    logic        busy;
    logic        cache_hit;
    logic [31:0] cache_result;

`ifdef MULDIV_SEQ_CACHE_EN
    logic        cache_valid_reg;
    logic [2:0]  cache_funct3_reg;
    logic [31:0] cache_a_reg;
    logic [31:0] cache_b_reg;
    logic [31:0] cache_result_reg;

    // Only normal completions are cached; flush leaves the entry intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_reg  <= 1'b0;
            cache_funct3_reg <= 3'd0;
            cache_a_reg      <= 32'd0;
            cache_b_reg      <= 32'd0;
            cache_result_reg <= 32'd0;
        end else if (busy && mul_finish_i && !flush_i) begin
            cache_valid_reg  <= 1'b1;
            cache_funct3_reg <= funct3_reg;
            cache_a_reg      <= a_reg;
            cache_b_reg      <= b_reg;
            cache_result_reg <= mul_result_i;
        end
    end

    assign cache_hit    = cache_valid_reg && (cache_funct3_reg == req_funct3_i) &&
                          (cache_a_reg == req_a_i) && (cache_b_reg == req_b_i);
    assign cache_result = cache_result_reg;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = 32'd0;
`endif

    assign busy        = (state_reg == BUSY);
    assign req_ready_o = !flush_i && ((state_reg == IDLE) ||
                                      ((state_reg == DONE) && resp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            funct3_reg <= 3'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            rd_reg     <= 5'd0;
            data_reg   <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            funct3_reg <= funct3_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            rd_reg     <= rd_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        funct3_next = funct3_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        rd_next     = rd_reg;
        data_next   = data_reg;
        err_next    = err_reg;

        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: ;
                BUSY: begin
                    if (mul_finish_i) begin
                        data_next  = mul_result_i;
                        err_next   = 1'b0;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (resp_ready_i)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase

            // A same-cycle acceptance in DONE overrides the return to IDLE.
            if (accept) begin
                rd_next = req_rd_i;
                if (req_funct3_i[2]) begin
                    data_next  = 32'd0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else if (cache_hit) begin
                    data_next  = cache_result;
                    err_next   = 1'b0;
                    state_next = DONE;
                end else begin
                    funct3_next = req_funct3_i;
                    a_next      = req_a_i;
                    b_next      = req_b_i;
                    state_next  = BUSY;
                end
            end
        end
    end

    assign mul_en_o     = busy;
    assign alu_stall_o  = busy;
    assign mul_funct3_o = funct3_reg;
    assign mul_a_o      = a_reg;
    assign mul_b_o      = b_reg;

    assign adder_opa_o  = busy ? mul_opa_i : alu_opa_i;
    assign adder_opb_o  = busy ? mul_opb_i : alu_opb_i;

    assign resp_valid_o = (state_reg == DONE);
    assign resp_data_o  = data_reg;
    assign resp_rd_o    = rd_reg;
    assign resp_err_o   = err_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table-driven multiply vectors plus flush, reset,
// back-to-back and spurious-finish sequences against a behavioural multiplier.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        flush = 1'b0;
    logic        mul_en;
    logic [2:0]  mul_funct3;
    logic [31:0] mul_a, mul_b;
    logic        mul_finish;
    logic [31:0] mul_result;
    logic [31:0] mul_opa = 32'd0, mul_opb = 32'd0;
    logic [31:0] alu_opa = 32'd0, alu_opb = 32'd0;
    logic [31:0] adder_opa, adder_opb;
    logic        alu_stall;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_funct3_i (req_funct3),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_rd_i     (req_rd),
        .flush_i      (flush),
        .mul_en_o     (mul_en),
        .mul_funct3_o (mul_funct3),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_finish_i (mul_finish),
        .mul_result_i (mul_result),
        .mul_opa_i    (mul_opa),
        .mul_opb_i    (mul_opb),
        .alu_opa_i    (alu_opa),
        .alu_opb_i    (alu_opb),
        .adder_opa_o  (adder_opa),
        .adder_opb_o  (adder_opb),
        .alu_stall_o  (alu_stall),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_rd_o    (resp_rd),
        .resp_err_o   (resp_err)
    );

    // Behavioural multiplier: MUL finishes in its 3rd enabled cycle, the high variants in the 4th.
    logic [2:0]  mcnt = 3'd0;
    logic        force_finish = 1'b0;
    logic        model_finish;
    logic [63:0] ext_a, ext_b, prod;

    always @(posedge clk) begin
        if (!mul_en) mcnt <= 3'd0;
        else         mcnt <= mcnt + 3'd1;
    end

    assign model_finish = mul_en && (mcnt == ((mul_funct3 == 3'b000) ? 3'd2 : 3'd3));
    assign mul_finish   = model_finish || force_finish;

    always_comb begin
        ext_a = {32'd0, mul_a};
        ext_b = {32'd0, mul_b};
        if (mul_funct3 == 3'b001 || mul_funct3 == 3'b010) ext_a = {{32{mul_a[31]}}, mul_a};
        if (mul_funct3 == 3'b001)                         ext_b = {{32{mul_b[31]}}, mul_b};
        prod = ext_a * ext_b;
    end

    assign mul_result = mul_finish ? ((mul_funct3 == 3'b000) ? prod[31:0] : prod[63:32])
                                   : 32'hDEADBEEF;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; presents a request and steps through the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        #1;
        check("req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Walks cycles T+1.. until resp_valid, checking the busy window each cycle.
    task automatic wait_resp(input string nm, input logic [31:0] exp_data, input logic exp_err,
                             input logic [4:0] exp_rd, input int exp_lat,
                             input logic [31:0] exp_a, input logic [31:0] exp_b);
        int  k = 1;
        int  bad = 0;
        int  en_cnt = 0;
        logic exp_busy;
        while (k <= 30) begin
            alu_opa = $urandom; alu_opb = $urandom;
            mul_opa = $urandom; mul_opb = $urandom;
            #1;
            exp_busy = (k < exp_lat);
            if (mul_en) en_cnt++;
            if (alu_stall !== exp_busy || mul_en !== exp_busy) bad++;
            if (adder_opa !== (exp_busy ? mul_opa : alu_opa)) bad++;
            if (adder_opb !== (exp_busy ? mul_opb : alu_opb)) bad++;
            if (exp_busy && (mul_a !== exp_a || mul_b !== exp_b)) bad++;
            if (resp_valid) break;
            @(posedge clk); #1;
            k++;
        end
        check({nm, " latency"}, k, exp_lat);
        check({nm, " window"}, bad, 0);
        check({nm, " en_cycles"}, en_cnt, exp_lat - 1);
        check({nm, " data"}, resp_data, exp_data);
        check({nm, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({nm, " rd"}, {27'd0, resp_rd}, {27'd0, exp_rd});
    endtask

    task automatic complete(input string nm);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({nm, " released"}, {31'd0, resp_valid}, 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int cache_lat;

        vecs[0] = '{"mul_7x6",     3'b000, 32'd7,         32'd6,         5'd5,  32'h0000002A, 1'b0, 4};
        vecs[1] = '{"mulh_m1",     3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd6,  32'h00000000, 1'b0, 5};
        vecs[2] = '{"mulhu_ff",    3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd7,  32'hFFFFFFFE, 1'b0, 5};
        vecs[3] = '{"mulhsu_min",  3'b010, 32'h80000000,  32'h00000002,  5'd8,  32'hFFFFFFFF, 1'b0, 5};
        vecs[4] = '{"div_err",     3'b100, 32'd10,        32'd3,         5'd9,  32'h00000000, 1'b1, 1};
        vecs[5] = '{"mul_wrap",    3'b000, 32'h00010000,  32'h00010000,  5'd31, 32'h00000000, 1'b0, 4};
        vecs[6] = '{"mul_neg",     3'b000, 32'hFFFFFFFF,  32'd3,         5'd1,  32'hFFFFFFFD, 1'b0, 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        alu_opa = 32'h13572468; alu_opb = 32'h2468ACE0;
        mul_opa = 32'h11111111; mul_opb = 32'h22222222;
        #1;
        check("rst req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst mul_en",     {31'd0, mul_en}, 32'd0);
        check("rst mul_funct3", {29'd0, mul_funct3}, 32'd0);
        check("rst mul_a",      mul_a, 32'd0);
        check("rst mul_b",      mul_b, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_data",  resp_data, 32'd0);
        check("rst resp_rd",    {27'd0, resp_rd}, 32'd0);
        check("rst resp_err",   {31'd0, resp_err}, 32'd0);
        check("rst alu_stall",  {31'd0, alu_stall}, 32'd0);
        check("rst adder_opa",  adder_opa, 32'h13572468);
        check("rst adder_opb",  adder_opb, 32'h2468ACE0);
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_resp(vecs[i].nm, vecs[i].data, vecs[i].err, vecs[i].rd, vecs[i].lat,
                      vecs[i].a, vecs[i].b);
            complete(vecs[i].nm);
        end

        // Spurious finish while idle must be ignored
        force_finish = 1'b1;
        @(posedge clk); #1;
        force_finish = 1'b0;
        check("idle_finish valid", {31'd0, resp_valid}, 32'd0);
        check("idle_finish en",    {31'd0, mul_en}, 32'd0);

        // Flush in cycle T+2 of a MULH, with a competing request presented
        issue(3'b001, 32'd3, 32'd4, 5'd10);
        @(posedge clk); #1;
        flush = 1'b1;
        req_valid = 1'b1; req_funct3 = 3'b000; req_a = 32'd2; req_b = 32'd2; req_rd = 5'd11;
        #1;
        check("flush req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush mul_en",     {31'd0, mul_en}, 32'd0);
        check("flush alu_stall",  {31'd0, alu_stall}, 32'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid || mul_en) bad++;
            @(posedge clk); #1;
        end
        check("flush no_resp", bad, 0);
        issue(3'b000, 32'd5, 32'd9, 5'd12);
        wait_resp("post_flush", 32'h0000002D, 1'b0, 5'd12, 4, 32'd5, 32'd9);
        complete("post_flush");

        // Stall in DONE for 3 cycles, spurious finish there, then back-to-back accept
        issue(3'b011, 32'd3, 32'd4, 5'd14);
        wait_resp("hold", 32'h00000000, 1'b0, 5'd14, 5, 32'd3, 32'd4);
        bad = 0;
        force_finish = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            force_finish = 1'b0;
            if (!resp_valid || resp_data !== 32'h0 || resp_rd !== 5'd14 || resp_err !== 1'b0) bad++;
        end
        check("hold stable", bad, 0);
        resp_ready = 1'b1;
        issue(3'b000, 32'd100, 32'd200, 5'd13);
        resp_ready = 1'b0;
        wait_resp("b2b", 32'h00004E20, 1'b0, 5'd13, 4, 32'd100, 32'd200);
        complete("b2b");

        // Reset in the middle of an operation
        issue(3'b001, 32'h1234, 32'h5678, 5'd20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst mul_en",     {31'd0, mul_en}, 32'd0);
        check("midrst mul_a",      mul_a, 32'd0);
        check("midrst mul_b",      mul_b, 32'd0);
        check("midrst mul_funct3", {29'd0, mul_funct3}, 32'd0);
        check("midrst resp_rd",    {27'd0, resp_rd}, 32'd0);
        check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst req_ready",  {31'd0, req_ready}, 32'd1);

        // Repeat of an identical request: served from the cache when it is built in
`ifdef MULDIV_SEQ_CACHE_EN
        cache_lat = 1;
`else
        cache_lat = 4;
`endif
        issue(3'b000, 32'd7, 32'd6, 5'd3);
        wait_resp("rep_first", 32'h0000002A, 1'b0, 5'd3, 4, 32'd7, 32'd6);
        complete("rep_first");
        issue(3'b000, 32'd7, 32'd6, 5'd4);
        wait_resp("rep_again", 32'h0000002A, 1'b0, 5'd4, cache_lat, 32'd7, 32'd6);
        complete("rep_again");
        issue(3'b000, 32'd7, 32'd5, 5'd2);
        wait_resp("rep_b5", 32'h00000023, 1'b0, 5'd2, 4, 32'd7, 32'd5);
        complete("rep_b5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer and adder arbiter for the iterative 16×16 fast multiplier in the execute stage. Accepts RV32M multiply requests from decode over a valid/ready handshake, latches the operands and holds the multiplier enabled until it finishes. While the multiplier is running, it owns the shared ALU adder and stalls the pipeline ALU. It then returns the 32-bit result over a valid/ready response port, and supports pipeline flush.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  multiply request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_funct3_i  in  3  RV32M funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- req_a_i, req_b_i  in  32 each  rs1 / rs2 values
- req_rd_i  in  5  destination register tag
- flush_i  in  1  kill any in-flight or pending operation
- mul_en_o  out  1  multiplier enable (held for whole operation)
- mul_funct3_o  out  3  latched funct3 to multiplier
- mul_a_o, mul_b_o  out  32 each  latched operands to multiplier
- mul_finish_i  in  1  multiplier last round (combinational)
- mul_result_i  in  32  multiplier result, valid when mul_finish_i
- mul_opa_i, mul_opb_i  in  32 each  multiplier adder operands
- alu_opa_i, alu_opb_i  in  32 each  pipeline ALU adder operands
- adder_opa_o, adder_opb_o  out  32 each  shared adder operands
- alu_stall_o  out  1  pipeline ALU must not use adder
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  writeback accepts result
- resp_data_o  out  32  result
- resp_rd_o  out  5  destination tag
- resp_err_o  out  1  request had funct3[2]=1 (division; not handled here)

## Operation
- States: IDLE, BUSY, DONE.
- req_ready_o = !flush_i && (IDLE || (DONE && resp_ready_i)).
- Accept with funct3[2]=0:
  - latch funct3, a, b, rd;
  - next state BUSY.
- Accept with funct3[2]=1:
  - next state DONE;
  - resp_data_o=0, resp_err_o=1;
  - multiplier not engaged.
- BUSY:
  - mul_en_o=1;
  - adder_op*_o = mul_op*_i;
  - alu_stall_o=1.
- BUSY && mul_finish_i:
  - register mul_result_i into resp_data_o;
  - resp_err_o=0;
  - next state DONE.
  - mul_en_o drops at that edge, so the multiplier clears its round counter.
- DONE:
  - resp_valid_o=1;
  - data and rd held stable until resp_ready_i.
- DONE && resp_ready_i: IDLE, or directly BUSY/DONE if a new request is accepted the same cycle.
- IDLE/DONE:
  - mul_en_o=0;
  - adder_op*_o = alu_op*_i;
  - alu_stall_o=0.
- mul_a_o, mul_b_o and mul_funct3_o change only on acceptance; they are stable throughout BUSY.
- flush_i (any state): next state IDLE, no response, no request accepted that cycle. Flush has priority over mul_finish_i and resp_ready_i.
- mul_finish_i outside BUSY is ignored.

## Timing
- Reset values:
  - state IDLE;
  - req_ready_o=1;
  - mul_en_o=0, mul_funct3_o=0, mul_a_o=0, mul_b_o=0;
  - resp_valid_o=0, resp_data_o=0, resp_rd_o=0, resp_err_o=0;
  - alu_stall_o=0;
  - adder outputs follow alu_op*_i.
- rst mid-operation aborts immediately, same as reset from power-up.
- Accept at edge T: BUSY from T+1.
- MUL: finish in cycle T+3, resp_valid_o from T+4.
- MULH/MULHSU/MULHU: finish in cycle T+4, resp_valid_o from T+5.
- Error response: resp_valid_o from T+1.
- Back-to-back: a new request is accepted in the response handshake cycle, so there is no idle bubble.
- Adder mux is purely combinational; alu_stall_o is registered-state decode, glitch-free per cycle.

## Configuration
- MULDIV_SEQ_CACHE_EN
  - Defined: one-entry result cache {valid, funct3, a, b, result}.
    - Written on every normal completion; cleared only by rst (flush does not clear it).
    - An accepted request matching all fields goes straight to DONE with the cached result (resp_valid_o at T+1, mul_en_o never asserted).
  - Undefined: no cache; every request runs the multiplier.

## Test plan
- MUL a=7, b=6 accepted at T -> resp_valid_o at T+4, resp_data_o=0x0000002A; mul_en_o high for exactly T+1..T+3.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_data_o=0x00000000 at T+5; MULHU same operands -> 0xFFFFFFFE.
- MULHSU a=0x80000000, b=0x00000002 -> 0xFFFFFFFF; alu_stall_o high T+1..T+4, adder_op*_o equal mul_op*_i only in those cycles.
- flush_i at T+2 of a MULH -> IDLE at T+3, mul_en_o low at T+3, no resp_valid_o; the next request completes correctly.
- resp_ready_i held low 3 cycles in DONE -> data/rd stable; new request in the handshake cycle accepted, BUSY next cycle. funct3=100 -> resp_err_o=1, data 0, T+1.
- With MULDIV_SEQ_CACHE_EN: repeat MUL 7×6 -> resp at T+1, mul_en_o never high; change b to 5 -> full latency, result 0x23.
